// File: rtl/max_pool_2x2_ctrl_pkg.sv
// Shared constants, FSM state encoding and the compare helper for the 2x2 max-pool stage.
package max_pool_2x2_ctrl_pkg;

    localparam int DATA_W     = 8;
    localparam int IMG_W      = 8;
    localparam int ADDR_W     = 7;
    localparam int BANK_SZ    = 2 * IMG_W;
    localparam int BANK0_BASE = 0;
    localparam int BANK1_BASE = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_OUT,
        ST_FREE
    } state_t;

    function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/max_pool_2x2_ctrl_if.sv
// Pooled-pixel stream: valid/ready handshake carrying the window maximum and a bank-end marker.
interface max_pool_2x2_ctrl_if;
    import max_pool_2x2_ctrl_pkg::*;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (output out_valid, output out_data, output out_last, input  out_ready);
    modport slave  (input  out_valid, input  out_data, input  out_last, output out_ready);

endinterface

// File: rtl/max_pool_2x2_ctrl.sv
// 2x2/stride-2 max pooling over a two-bank ping-pong buffer, banks consumed strictly alternating.
// Latency: first read 1 cycle after a pending bank is seen; result 5 cycles after the first read; >=6 cycles/window.
// Backpressure: holds the result in OUT with no reads issued until out_ready; the bank is freed after its last window.
module max_pool_2x2_ctrl
    import max_pool_2x2_ctrl_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                bank_full,
    output logic [1:0]                bank_free,
    output logic                      rd_en,
    output logic [ADDR_W-1:0]         rd_addr,
    input  logic [DATA_W-1:0]         rd_data,
    max_pool_2x2_ctrl_if.master       out_if
);

    localparam int WINS  = IMG_W / 2;
    localparam int WIN_W = (WINS > 1) ? $clog2(WINS) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINS - 1);

    state_t            state;
    logic [1:0]        pending;
    logic              cur_bank;
    logic [WIN_W-1:0]  win;
    logic [1:0]        k;
    logic [DATA_W-1:0] max_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_last_q;

    // k selects the window corner: bit0 = column offset, bit1 = second row.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic             bank,
                                                   input logic [WIN_W-1:0] w,
                                                   input logic [1:0]       kk);
        logic [ADDR_W-1:0] a;
        a = bank ? ADDR_W'(BANK1_BASE) : ADDR_W'(BANK0_BASE);
        a = a + (ADDR_W'(w) << 1) + ADDR_W'(kk[0]);
        if (kk[1]) a = a + ADDR_W'(IMG_W);
        return a;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            pending     <= 2'b00;
            cur_bank    <= 1'b0;
            win         <= '0;
            k           <= 2'd0;
            max_q       <= '0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            bank_free   <= 2'b00;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            bank_free <= 2'b00;
            pending   <= pending | bank_full;
            case (state)
                ST_IDLE: begin
                    if (pending[cur_bank]) begin
                        state   <= ST_RD;
                        win     <= '0;
                        k       <= 2'd0;
                        rd_en   <= 1'b1;
                        rd_addr <= pix_addr(cur_bank, '0, 2'd0);
                    end
                end
                ST_RD: begin
                    // rd_data lags rd_en by one cycle, so corner k-1 arrives while k is issued.
                    if (k == 2'd1)      max_q <= rd_data;
                    else if (k != 2'd0) max_q <= max2(max_q, rd_data);
                    if (k == 2'd3) begin
                        rd_en <= 1'b0;
                        state <= ST_WAIT;
                    end else begin
                        rd_addr <= pix_addr(cur_bank, win, k + 2'd1);
                    end
                    k <= k + 2'd1;
                end
                ST_WAIT: begin
                    out_data_q  <= max2(max_q, rd_data);
                    out_last_q  <= (win == WIN_LAST);
                    out_valid_q <= 1'b1;
                    state       <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_if.out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (win != WIN_LAST) begin
                            win     <= WIN_W'(win + 1'b1);
                            k       <= 2'd0;
                            rd_en   <= 1'b1;
                            rd_addr <= pix_addr(cur_bank, WIN_W'(win + 1'b1), 2'd0);
                            state   <= ST_RD;
                        end else begin
                            bank_free[cur_bank] <= 1'b1;
                            state               <= ST_FREE;
                        end
                    end
                end
                ST_FREE: begin
                    // A fresh bank_full landing on this same edge must survive the clear.
                    pending  <= (pending & ~(2'b01 << cur_bank)) | bank_full;
                    cur_bank <= ~cur_bank;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign out_if.out_valid = out_valid_q;
    assign out_if.out_data  = out_data_q;
    assign out_if.out_last  = out_last_q;

endmodule

// File: tb/tb_max_pool_2x2_ctrl.sv
// Scoreboard bench for max_pool_2x2_ctrl: RAM model, expected window maxima queued at bank hand-off.
module tb_max_pool_2x2_ctrl;
    import max_pool_2x2_ctrl_pkg::*;

    typedef struct packed {
        logic [DATA_W-1:0] dat;
        logic              last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        bank_full;
    logic [1:0]        bank_free;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    logic [DATA_W-1:0] mem [32];
    exp_t              sb [$];
    int                free_log [$];
    exp_t              mon_e;
    int                n_tests = 0;
    int                n_fail  = 0;
    int                n_acc   = 0;

    always #5 clk = ~clk;

    max_pool_2x2_ctrl_if ob ();

    max_pool_2x2_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .bank_full (bank_full),
        .bank_free (bank_free),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_if    (ob)
    );

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr[4:0]];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (ob.out_valid && ob.out_ready) begin
                chk("sb_nonempty", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    chk("out_data", 32'(ob.out_data), 32'(mon_e.dat));
                    chk("out_last", 32'(ob.out_last), 32'(mon_e.last));
                end
                n_acc++;
            end
            if (ob.out_valid) chk("rd_en_in_out", 32'(rd_en), 0);
            if (rd_en) chk("rd_addr_range", 32'(rd_addr < 7'd32), 1);
            if (bank_free != 2'b00) begin
                chk("bank_free_onehot", 32'(bank_free == 2'b11), 0);
                free_log.push_back(int'(bank_free[1]));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_full(input logic [1:0] b);
        bank_full = b;
        tick(1);
        bank_full = 2'b00;
    endtask

    task automatic push_bank(input int b, input int nwin);
        for (int w = 0; w < nwin; w++) begin
            int a;
            logic [DATA_W-1:0] m;
            a = b * 16 + 2 * w;
            m = mem[a];
            if (mem[a + 1] > m) m = mem[a + 1];
            if (mem[a + 8] > m) m = mem[a + 8];
            if (mem[a + 9] > m) m = mem[a + 9];
            sb.push_back({m, logic'(w == 3)});
        end
    endtask

    task automatic fill_rand(input int b);
        for (int a = 0; a < 16; a++) mem[b * 16 + a] = DATA_W'($urandom_range(0, 255));
    endtask

    task automatic wait_drain(input string tag, input int nfree);
        int t = 0;
        while ((sb.size() != 0 || free_log.size() < nfree) && t < 2000) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk({tag, "_drain"}, 32'(t < 2000), 1);
    endtask

    task automatic chk_free(input string tag, input int exp_bank);
        int got = 99;
        if (free_log.size() > 0) got = free_log.pop_front();
        chk(tag, 32'(got), 32'(exp_bank));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int t_rd;
        int t_ov;
        int nrd;
        int nbad;
        int base;
        logic [DATA_W-1:0] hold_dat;

        rst          = 1'b0;
        bank_full    = 2'b00;
        ob.out_ready = 1'b0;
        rd_data      = '0;
        for (int a = 0; a < 32; a++) mem[a] = '0;
        #2;
        chk("rst_rd_en",     32'(rd_en), 0);
        chk("rst_rd_addr",   32'(rd_addr), 0);
        chk("rst_out_valid", 32'(ob.out_valid), 0);
        chk("rst_out_data",  32'(ob.out_data), 0);
        chk("rst_out_last",  32'(ob.out_last), 0);
        chk("rst_bank_free", 32'(bank_free), 0);
        tick(3);
        rst          = 1'b1;
        ob.out_ready = 1'b1;
        tick(2);

        // Ramp bank0: pixel = address, plus startup latency.
        for (int a = 0; a < 16; a++) mem[a] = DATA_W'(a);
        push_bank(0, 4);
        bank_full = 2'b01;
        @(posedge clk);
        #1 bank_full = 2'b00;
        t = 0; t_rd = 0; t_ov = 0;
        while (t < 50 && t_ov == 0) begin
            @(negedge clk);
            t++;
            if (rd_en && t_rd == 0) t_rd = t;
            if (ob.out_valid) t_ov = t;
        end
        chk("lat_first_rd", 32'(t_rd), 2);
        chk("lat_out_valid", 32'(t_ov - t_rd), 5);
        wait_drain("ramp", 1);
        tick(3);
        chk_free("ramp_free", 0);
        chk("ramp_free_once", 32'(free_log.size()), 0);

        // Bank1: 200 placed at a different window corner each window.
        for (int a = 16; a < 32; a++) mem[a] = DATA_W'($urandom_range(0, 199));
        for (int w = 0; w < 4; w++)
            mem[16 + 2 * w + (w & 1) + ((w >> 1) * 8)] = 8'd200;
        push_bank(1, 4);
        pulse_full(2'b10);
        wait_drain("corner", 1);
        chk_free("corner_free", 1);

        // Both banks announced together.
        fill_rand(0); fill_rand(1);
        push_bank(0, 4); push_bank(1, 4);
        pulse_full(2'b11);
        wait_drain("both", 2);
        chk_free("both_free0", 0);
        chk_free("both_free1", 1);

        // Bank1 ready first: bank0 must still go first.
        fill_rand(0); fill_rand(1);
        push_bank(0, 4); push_bank(1, 4);
        pulse_full(2'b10);
        nrd = 0;
        repeat (20) begin
            @(negedge clk);
            if (rd_en) nrd++;
        end
        chk("order_no_rd", 32'(nrd), 0);
        @(posedge clk); #1;
        pulse_full(2'b01);
        wait_drain("order", 2);
        chk_free("order_free0", 0);
        chk_free("order_free1", 1);

        // Backpressure on window 2 for 10 cycles.
        fill_rand(0);
        push_bank(0, 4);
        base = n_acc;
        pulse_full(2'b01);
        t = 0;
        while (n_acc < base + 2 && t < 200) begin @(negedge clk); t++; end
        chk("bp_reach_win2", 32'(t < 200), 1);
        @(posedge clk); #1 ob.out_ready = 1'b0;
        t = 0;
        while (!ob.out_valid && t < 50) begin @(negedge clk); t++; end
        chk("bp_valid_rise", 32'(ob.out_valid), 1);
        hold_dat = ob.out_data;
        chk("bp_data", 32'(hold_dat), 32'(sb[0].dat));
        nbad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!ob.out_valid || ob.out_data != hold_dat || rd_en) nbad++;
        end
        chk("bp_stable", 32'(nbad), 0);
        @(posedge clk); #1 ob.out_ready = 1'b1;
        wait_drain("bp", 1);
        chk_free("bp_free", 0);

        // Reset during window 1 reads of bank1.
        fill_rand(1);
        push_bank(1, 1);
        base = n_acc;
        pulse_full(2'b10);
        t = 0;
        while (n_acc < base + 1 && t < 200) begin @(negedge clk); t++; end
        chk("abort_win0", 32'(t < 200), 1);
        t = 0;
        do begin @(negedge clk); t++; end while (!rd_en && t < 20);
        chk("abort_in_rd", 32'(rd_en), 1);
        #1 rst = 1'b0;
        #1;
        chk("abort_rd_en",     32'(rd_en), 0);
        chk("abort_rd_addr",   32'(rd_addr), 0);
        chk("abort_out_valid", 32'(ob.out_valid), 0);
        chk("abort_out_data",  32'(ob.out_data), 0);
        chk("abort_bank_free", 32'(bank_free), 0);
        tick(2);
        rst = 1'b1;
        nrd = 0;
        repeat (20) begin
            @(negedge clk);
            if (rd_en || ob.out_valid) nrd++;
        end
        chk("abort_idle", 32'(nrd), 0);
        chk("abort_no_free", 32'(free_log.size()), 0);
        @(posedge clk); #1;
        fill_rand(0);
        push_bank(0, 4);
        pulse_full(2'b01);
        wait_drain("restart", 1);
        chk_free("restart_free", 0);

        tick(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
